// File: rtl/dcache_miss_ctrl.sv
// Data-cache load miss controller: returns hits, tracks misses in MSHRs, issues bus loads, writes fills.
// Optional DCACHE_MSHR_MERGE_EN: a miss to an in-flight block rides on its primary instead of stalling.
module dcache_miss_ctrl #(
    parameter int NUM_MSHR = 4,
    parameter int ID_W     = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ld_valid,
    input  logic [63:0]     ld_addr,
    input  logic [ID_W-1:0] ld_id,
    output logic            ld_ready,
    output logic [6:0]      rd1_idx,
    output logic [21:0]     rd1_tag,
    input  logic            rd1_valid,
    input  logic [63:0]     rd1_data,
    output logic [1:0]      Dmem_command,
    output logic [63:0]     Dmem_addr,
    input  logic [3:0]      Dmem_response,
    input  logic [3:0]      Dmem_tag,
    input  logic [63:0]     Dmem_data,
    output logic            wr0_en,
    output logic [6:0]      wr0_idx,
    output logic [21:0]     wr0_tag,
    output logic [63:0]     wr0_data,
    output logic            done_valid,
    output logic [ID_W-1:0] done_id,
    output logic [63:0]     done_data,
    output logic            mshr_empty
);
    localparam int MI_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [2:0] {M_FREE, M_ISSUE, M_WAIT, M_MERGED, M_PEND} mshr_state_e;

    mshr_state_e     r_state [NUM_MSHR];
    logic [6:0]      r_idx   [NUM_MSHR];
    logic [21:0]     r_tag   [NUM_MSHR];
    logic [ID_W-1:0] r_id    [NUM_MSHR];
    logic [3:0]      r_mtag  [NUM_MSHR];
    logic [63:0]     r_data  [NUM_MSHR];

    logic [6:0]      w_ld_idx;
    logic [21:0]     w_ld_tag;
    logic            w_iss_v, w_fill_v, w_pend_v, w_free_v, w_conflict, w_empty;
    logic [MI_W-1:0] w_iss_i, w_fill_i, w_pend_i, w_free_i;
    logic            w_alloc_ok, w_acc, w_hit, w_miss, w_resp;
    logic            w_unused;

    assign w_ld_idx = ld_addr[9:3];
    assign w_ld_tag = ld_addr[31:10];
    assign rd1_idx  = w_ld_idx;
    assign rd1_tag  = w_ld_tag;
    assign w_unused = ^{ld_addr[63:32], ld_addr[2:0]};

    // Scan high to low so the lowest matching index is the one left selected.
    always_comb begin
        w_iss_v    = 1'b0;
        w_iss_i    = '0;
        w_fill_v   = 1'b0;
        w_fill_i   = '0;
        w_pend_v   = 1'b0;
        w_pend_i   = '0;
        w_free_v   = 1'b0;
        w_free_i   = '0;
        w_conflict = 1'b0;
        w_empty    = 1'b1;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (r_state[i] == M_ISSUE) begin
                w_iss_v = 1'b1;
                w_iss_i = MI_W'(i);
            end
            if (r_state[i] == M_WAIT && Dmem_tag != 4'd0 && r_mtag[i] == Dmem_tag) begin
                w_fill_v = 1'b1;
                w_fill_i = MI_W'(i);
            end
            if (r_state[i] == M_PEND) begin
                w_pend_v = 1'b1;
                w_pend_i = MI_W'(i);
            end
            if (r_state[i] == M_FREE) begin
                w_free_v = 1'b1;
                w_free_i = MI_W'(i);
            end else begin
                w_empty = 1'b0;
            end
            if ((r_state[i] == M_ISSUE || r_state[i] == M_WAIT) &&
                r_idx[i] == w_ld_idx && r_tag[i] == w_ld_tag)
                w_conflict = 1'b1;
        end
    end

`ifdef DCACHE_MSHR_MERGE_EN
    assign w_alloc_ok = w_free_v;
`else
    assign w_alloc_ok = w_free_v && !w_conflict;
`endif

    assign ld_ready = !w_fill_v && !w_pend_v && (rd1_valid || w_alloc_ok);
    assign w_acc    = ld_valid && ld_ready;
    assign w_hit    = w_acc && rd1_valid;
    assign w_miss   = w_acc && !rd1_valid;
    assign w_resp   = w_iss_v && Dmem_response != 4'd0;

    assign Dmem_command = w_iss_v ? BUS_LOAD : BUS_NONE;
    assign Dmem_addr    = w_iss_v ? {32'd0, r_tag[w_iss_i], r_idx[w_iss_i], 3'b000} : 64'd0;
    assign wr0_en       = w_fill_v;
    assign wr0_idx      = r_idx[w_fill_i];
    assign wr0_tag      = r_tag[w_fill_i];
    assign wr0_data     = Dmem_data;
    assign mshr_empty   = w_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                r_state[i] <= M_FREE;
                r_idx[i]   <= '0;
                r_tag[i]   <= '0;
                r_id[i]    <= '0;
                r_mtag[i]  <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                if (w_resp && w_iss_i == MI_W'(i)) begin
                    r_state[i] <= M_WAIT;
                    r_mtag[i]  <= Dmem_response;
                end
                if (w_fill_v && w_fill_i == MI_W'(i))
                    r_state[i] <= M_FREE;
                // Secondaries waiting on the filled block capture its data alongside the primary.
                if (w_fill_v && r_state[i] == M_MERGED &&
                    r_idx[i] == r_idx[w_fill_i] && r_tag[i] == r_tag[w_fill_i]) begin
                    r_state[i] <= M_PEND;
                    r_data[i]  <= Dmem_data;
                end
                if (w_pend_v && w_pend_i == MI_W'(i))
                    r_state[i] <= M_FREE;
                if (w_miss && w_free_i == MI_W'(i)) begin
`ifdef DCACHE_MSHR_MERGE_EN
                    r_state[i] <= w_conflict ? M_MERGED : M_ISSUE;
`else
                    r_state[i] <= M_ISSUE;
`endif
                    r_idx[i] <= w_ld_idx;
                    r_tag[i] <= w_ld_tag;
                    r_id[i]  <= ld_id;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_valid <= 1'b0;
            done_id    <= '0;
            done_data  <= '0;
        end else begin
            done_valid <= w_fill_v || w_pend_v || w_hit;
            if (w_fill_v) begin
                done_id   <= r_id[w_fill_i];
                done_data <= Dmem_data;
            end else if (w_pend_v) begin
                done_id   <= r_id[w_pend_i];
                done_data <= r_data[w_pend_i];
            end else if (w_hit) begin
                done_id   <= ld_id;
                done_data <= rd1_data;
            end
        end
    end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: hit vector table, directed miss/merge/full/reorder/reset sequences, random run vs model.
module tb_dcache_miss_ctrl;
    localparam int NM = 4;
    localparam int IW = 5;
`ifdef DCACHE_MSHR_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          ld_valid, ld_ready, rd1_valid, wr0_en, done_valid, mshr_empty;
    logic [63:0]   ld_addr, rd1_data, Dmem_addr, Dmem_data, wr0_data, done_data;
    logic [IW-1:0] ld_id, done_id;
    logic [6:0]    rd1_idx, wr0_idx;
    logic [21:0]   rd1_tag, wr0_tag;
    logic [1:0]    Dmem_command;
    logic [3:0]    Dmem_response, Dmem_tag;

    always #5 clock = ~clock;

    dcache_miss_ctrl #(.NUM_MSHR(NM), .ID_W(IW)) dut (
        .clock(clock), .reset(reset),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_id(ld_id), .ld_ready(ld_ready),
        .rd1_idx(rd1_idx), .rd1_tag(rd1_tag), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .Dmem_command(Dmem_command), .Dmem_addr(Dmem_addr), .Dmem_response(Dmem_response),
        .Dmem_tag(Dmem_tag), .Dmem_data(Dmem_data),
        .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_tag(wr0_tag), .wr0_data(wr0_data),
        .done_valid(done_valid), .done_id(done_id), .done_data(done_data),
        .mshr_empty(mshr_empty)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drv(input logic v, input logic [63:0] a, input logic [IW-1:0] id,
                       input logic hv, input logic [63:0] hd,
                       input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] dd);
        ld_valid = v; ld_addr = a; ld_id = id;
        rd1_valid = hv; rd1_data = hd;
        Dmem_response = rsp; Dmem_tag = tg; Dmem_data = dd;
    endtask

    task automatic idle();
        drv(1'b0, 64'd0, '0, 1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [63:0]   addr;
        logic [63:0]   hd;
        logic [IW-1:0] id;
        logic [6:0]    eidx;
        logic [21:0]   etag;
        logic          erdy;
    } vec_t;

    // Reference model: per-slot bookkeeping plus a direct-mapped picture of the cache array.
    typedef struct {
        bit used; bit prim; bit sent; bit got;
        logic [3:0] mt; logic [6:0] ix; logic [21:0] tg; logic [IW-1:0] id; logic [63:0] d;
    } slot_t;
    slot_t       ms[NM];
    bit          cval[128];
    logic [21:0] ctag[128];
    logic [63:0] cdat[128];

    function automatic bit tag_busy(input logic [3:0] t);
        for (int i = 0; i < NM; i++)
            if (ms[i].used && ms[i].sent && ms[i].mt == t) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        vec_t tbl[4];
        tbl[0] = '{64'h1238, 64'hDEAD, 5'd3, 7'h47, 22'h4, 1'b1};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 5'd31, 7'h7F, 22'h3FFFFF, 1'b1};
        tbl[2] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 7'h00, 22'h0, 1'b1};
        tbl[3] = '{64'h0000_0000_8000_0400, 64'h5555, 5'd17, 7'h00, 22'h200001, 1'b1};

        idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_done_data", done_data, 0);
        chk("rst_cmd", Dmem_command, 0);
        chk("rst_wr0_en", wr0_en, 0);
        chk("rst_empty", mshr_empty, 1);
        chk("rst_ready", ld_ready, 1);
        reset = 1'b1;
        tick();

        // Hits from the table
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, tbl[i].addr, tbl[i].id, 1'b1, tbl[i].hd, 4'd0, 4'd0, 64'd0);
            #1;
            chk("hit_idx", rd1_idx, tbl[i].eidx);
            chk("hit_tag", rd1_tag, tbl[i].etag);
            chk("hit_ready", ld_ready, tbl[i].erdy);
            chk("hit_cmd", Dmem_command, 0);
            tick();
            chk("hit_done_valid", done_valid, 1);
            chk("hit_done_id", done_id, tbl[i].id);
            chk("hit_done_data", done_data, tbl[i].hd);
        end
        idle();
        tick();
        chk("hit_done_clear", done_valid, 0);

        // Miss with one refused bus attempt
        drv(1'b1, 64'h1238, 5'd7, 1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
        #1; chk("miss_ready", ld_ready, 1); chk("miss_cmd0", Dmem_command, 0);
        tick(); idle(); #1;
        chk("retry_cmd1", Dmem_command, 1); chk("retry_addr1", Dmem_addr, 64'h1238);
        tick(); Dmem_response = 4'd5; #1;
        chk("retry_cmd2", Dmem_command, 1); chk("retry_addr2", Dmem_addr, 64'h1238);
        tick(); drv(1'b0, 64'd0, '0, 1'b0, 64'd0, 4'd0, 4'd5, 64'hBEEF); #1;
        chk("fill_cmd", Dmem_command, 0); chk("fill_en", wr0_en, 1);
        chk("fill_idx", wr0_idx, 7'h47); chk("fill_tag", wr0_tag, 22'h4);
        chk("fill_data", wr0_data, 64'hBEEF); chk("fill_empty", mshr_empty, 0);
        tick();
        chk("miss_done_valid", done_valid, 1); chk("miss_done_id", done_id, 7);
        chk("miss_done_data", done_data, 64'hBEEF);
        idle(); #1; chk("miss_empty", mshr_empty, 1);

        // Second miss to an in-flight block
        tick();
        drv(1'b1, 64'h1238, 5'd1, 1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
        #1; chk("mrg_ready1", ld_ready, 1);
        tick(); drv(1'b1, 64'h1238, 5'd2, 1'b0, 64'd0, 4'd3, 4'd0, 64'd0);
        #1; chk("mrg_ready2", ld_ready, MERGE); chk("mrg_cmd", Dmem_command, 1);
        if (MERGE) begin
            tick(); drv(1'b0, 64'd0, '0, 1'b0, 64'd0, 4'd0, 4'd3, 64'hBEEF); #1;
            chk("mrg_one_bus", Dmem_command, 0); chk("mrg_fill", wr0_en, 1);
            tick();
            chk("mrg_done1", done_valid, 1); chk("mrg_id1", done_id, 1); chk("mrg_data1", done_data, 64'hBEEF);
            idle(); #1; chk("mrg_pend_blocks", ld_ready, 0);
            tick();
            chk("mrg_done2", done_valid, 1); chk("mrg_id2", done_id, 2); chk("mrg_data2", done_data, 64'hBEEF);
            idle();
        end else begin
            tick(); drv(1'b1, 64'h1238, 5'd2, 1'b0, 64'd0, 4'd0, 4'd3, 64'hBEEF); #1;
            chk("hold_ready_fill", ld_ready, 0); chk("hold_fill", wr0_en, 1); chk("hold_cmd", Dmem_command, 0);
            tick();
            chk("hold_done1", done_valid, 1); chk("hold_id1", done_id, 1); chk("hold_data1", done_data, 64'hBEEF);
            drv(1'b1, 64'h1238, 5'd2, 1'b1, 64'hBEEF, 4'd0, 4'd0, 64'd0); #1;
            chk("hold_ready_hit", ld_ready, 1);
            tick();
            chk("hold_done2", done_valid, 1); chk("hold_id2", done_id, 2); chk("hold_data2", done_data, 64'hBEEF);
            idle();
        end
        #1; chk("mrg_empty", mshr_empty, 1);
        tick(); chk("mrg_done_clear", done_valid, 0);

        // All MSHRs busy
        for (int i = 0; i < NM; i++) begin
            drv(1'b1, 64'((i + 1) << 3), IW'(i), 1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
            #1; chk("full_alloc_ready", ld_ready, 1);
            tick();
        end
        drv(1'b1, 64'h800, 5'd9, 1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
        #1; chk("full_ready", ld_ready, 0); chk("full_empty", mshr_empty, 0);
        drv(1'b1, 64'h800, 5'd9, 1'b1, 64'hCAFE, 4'd0, 4'd0, 64'd0);
        #1; chk("full_hit_ready", ld_ready, 1);
        tick();
        chk("full_hit_done", done_valid, 1); chk("full_hit_id", done_id, 9); chk("full_hit_data", done_data, 64'hCAFE);
        do_reset();

        // Out-of-order fills
        drv(1'b1, 64'h100, 5'd4, 1'b0, 64'd0, 4'd0, 4'd0, 64'd0); #1; chk("ooo_ready", ld_ready, 1);
        tick(); drv(1'b1, 64'h208, 5'd6, 1'b0, 64'd0, 4'd1, 4'd0, 64'd0); #1;
        chk("ooo_cmd_a", Dmem_command, 1); chk("ooo_addr_a", Dmem_addr, 64'h100);
        tick(); drv(1'b0, 64'd0, '0, 1'b0, 64'd0, 4'd2, 4'd0, 64'd0); #1;
        chk("ooo_cmd_b", Dmem_command, 1); chk("ooo_addr_b", Dmem_addr, 64'h208);
        tick(); drv(1'b0, 64'd0, '0, 1'b0, 64'd0, 4'd0, 4'd2, 64'h2222); #1;
        chk("ooo_fill_b", wr0_en, 1); chk("ooo_idx_b", wr0_idx, 7'h41); chk("ooo_tag_b", wr0_tag, 0);
        tick();
        chk("ooo_done_b", done_valid, 1); chk("ooo_id_b", done_id, 6); chk("ooo_data_b", done_data, 64'h2222);
        drv(1'b0, 64'd0, '0, 1'b0, 64'd0, 4'd0, 4'd1, 64'h1111); #1;
        chk("ooo_fill_a", wr0_en, 1); chk("ooo_idx_a", wr0_idx, 7'h20);
        tick();
        chk("ooo_done_a", done_valid, 1); chk("ooo_id_a", done_id, 4); chk("ooo_data_a", done_data, 64'h1111);
        idle(); #1; chk("ooo_empty", mshr_empty, 1);

        // Asynchronous reset with two misses outstanding
        tick(); drv(1'b1, 64'h100, 5'd4, 1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
        tick(); drv(1'b1, 64'h208, 5'd6, 1'b0, 64'd0, 4'd1, 4'd0, 64'd0);
        tick(); drv(1'b1, 64'h3000, 5'd12, 1'b1, 64'hAB, 4'd2, 4'd0, 64'd0);
        tick(); idle();
        chk("ar_pre_done", done_valid, 1); chk("ar_pre_empty", mshr_empty, 0);
        reset = 1'b0; #1;
        chk("ar_done_valid", done_valid, 0); chk("ar_done_id", done_id, 0); chk("ar_done_data", done_data, 0);
        chk("ar_empty", mshr_empty, 1); chk("ar_cmd", Dmem_command, 0);
        #1; reset = 1'b1;
        drv(1'b0, 64'd0, '0, 1'b0, 64'd0, 4'd0, 4'd1, 64'h99); #1;
        chk("ar_stale_wr", wr0_en, 0);
        tick(); chk("ar_stale_done", done_valid, 0);
        do_reset();

        // Random traffic against the reference model
        begin
            bit            exp_dv = 1'b0;
            logic [IW-1:0] exp_id = '0;
            logic [63:0]   exp_d  = '0;
            for (int i = 0; i < NM; i++) ms[i] = '{default: '0};
            for (int i = 0; i < 128; i++) cval[i] = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                logic [6:0]    ix;
                logic [21:0]   tg;
                logic          v, hv;
                logic [63:0]   hd, dd;
                logic [IW-1:0] id;
                logic [3:0]    rsp, dtag;
                int            iss, fill, pend, fre;
                bit            confl, rdy;
                if (c > 0) begin
                    chk("rnd_done_valid", done_valid, exp_dv);
                    if (exp_dv) begin
                        chk("rnd_done_id", done_id, exp_id);
                        chk("rnd_done_data", done_data, exp_d);
                    end
                end
                ix = 7'($urandom_range(0, 3));
                tg = 22'($urandom_range(0, 2));
                v  = ($urandom_range(0, 2) != 0);
                id = IW'($urandom());
                hv = cval[ix] && ctag[ix] == tg;
                hd = hv ? cdat[ix] : {$urandom(), $urandom()};
                dd = {$urandom(), $urandom()};
                iss = -1;
                for (int i = NM - 1; i >= 0; i--)
                    if (ms[i].used && ms[i].prim && !ms[i].sent) iss = i;
                rsp = 4'd0;
                if (iss >= 0 && $urandom_range(0, 2) != 0)
                    do rsp = 4'($urandom_range(1, 15)); while (tag_busy(rsp));
                dtag = 4'd0;
                if ($urandom_range(0, 1) == 1) begin
                    int k = $urandom_range(0, NM - 1);
                    if (ms[k].used && ms[k].sent) dtag = ms[k].mt;
                    else if ($urandom_range(0, 3) == 0) dtag = 4'($urandom_range(1, 15));
                end
                drv(v, {$urandom(), tg, ix, 3'($urandom())}, id, hv, hd, rsp, dtag, dd);
                #1;
                fill = -1; pend = -1; fre = -1; confl = 1'b0;
                for (int i = NM - 1; i >= 0; i--) begin
                    if (ms[i].used && ms[i].prim && ms[i].sent && dtag != 0 && ms[i].mt == dtag) fill = i;
                    if (ms[i].used && !ms[i].prim && ms[i].got) pend = i;
                    if (!ms[i].used) fre = i;
                    if (ms[i].used && ms[i].prim && ms[i].ix == ix && ms[i].tg == tg) confl = 1'b1;
                end
                rdy = fill < 0 && pend < 0 && (hv || (fre >= 0 && (MERGE || !confl)));
                chk("rnd_ready", ld_ready, rdy);
                chk("rnd_cmd", Dmem_command, (iss >= 0) ? 1 : 0);
                if (iss >= 0) chk("rnd_addr", Dmem_addr, {32'd0, ms[iss].tg, ms[iss].ix, 3'd0});
                chk("rnd_wr0_en", wr0_en, fill >= 0);
                if (fill >= 0) begin
                    chk("rnd_wr0_idx", wr0_idx, ms[fill].ix);
                    chk("rnd_wr0_tag", wr0_tag, ms[fill].tg);
                end
                chk("rnd_empty", mshr_empty, fre >= 0 && ms[0].used == 0 && ms[NM-1].used == 0 &&
                    !(ms[1].used || ms[2].used));
                exp_dv = 1'b0;
                if (fill >= 0) begin
                    exp_dv = 1'b1; exp_id = ms[fill].id; exp_d = dd;
                    cval[ms[fill].ix] = 1'b1; ctag[ms[fill].ix] = ms[fill].tg; cdat[ms[fill].ix] = dd;
                    for (int i = 0; i < NM; i++)
                        if (ms[i].used && !ms[i].prim && !ms[i].got &&
                            ms[i].ix == ms[fill].ix && ms[i].tg == ms[fill].tg) begin
                            ms[i].got = 1'b1; ms[i].d = dd;
                        end
                    ms[fill].used = 1'b0;
                end else if (pend >= 0) begin
                    exp_dv = 1'b1; exp_id = ms[pend].id; exp_d = ms[pend].d;
                    ms[pend].used = 1'b0;
                end else if (v && rdy && hv) begin
                    exp_dv = 1'b1; exp_id = id; exp_d = hd;
                end
                if (iss >= 0 && rsp != 0) begin
                    ms[iss].sent = 1'b1; ms[iss].mt = rsp;
                end
                if (v && rdy && !hv)
                    ms[fre] = '{1'b1, !confl, 1'b0, 1'b0, 4'd0, ix, tg, id, 64'd0};
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dcache_miss_ctrl.md
# dcache_miss_ctrl

Load-side miss controller for the data cache. Accepts one load per cycle from the LSQ, looks it up in the data cache storage array, and returns hits directly. On a miss it allocates an MSHR, issues a BUS_LOAD to data memory, matches the returning memory tag, writes the fill into the array through write port 0, and returns the load result. Sits between the LSQ and the cache storage array / Dmem bus.

## Interface
Parameters:
- NUM_MSHR, 4: outstanding-miss entries (2..8)
- ID_W, 5: width of the load identifier returned with data

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ld_valid  in  1  load request present
- ld_addr  in  64  byte address; [9:3] index, [31:10] tag, [2:0] ignored
- ld_id  in  ID_W  requester id, echoed on completion
- ld_ready  out  1  request accepted this cycle when high with ld_valid
- rd1_idx  out  7  array lookup index = ld_addr[9:3], combinational
- rd1_tag  out  22  array lookup tag = ld_addr[31:10], combinational
- rd1_valid  in  1  array hit
- rd1_data  in  64  array data
- Dmem_command  out  2  0 = BUS_NONE, 1 = BUS_LOAD
- Dmem_addr  out  64  block address of issuing MSHR, [2:0] = 0
- Dmem_response  in  4  nonzero = accepted, value is transaction tag
- Dmem_tag  in  4  nonzero = data for that transaction tag on Dmem_data
- Dmem_data  in  64  fill data
- wr0_en  out  1  array fill write, combinational
- wr0_idx  out  7  fill index
- wr0_tag  out  22  fill tag
- wr0_data  out  64  fill data (= Dmem_data)
- done_valid  out  1  registered load completion
- done_id  out  ID_W  completed load id
- done_data  out  64  completed load data
- mshr_empty  out  1  no MSHR in use (halt drain)

## Operation
- MSHR entry fields: state, idx, tag, id, mem_tag (4b), data (64b), primary flag.
- Entry states: FREE -> ISSUE -> WAIT -> FREE (primary); FREE -> MERGED -> PEND -> FREE (secondary).
- ISSUE: lowest-index ISSUE entry drives BUS_LOAD/Dmem_addr; Dmem_response != 0 latches mem_tag, -> WAIT; 0 -> stays ISSUE, retries next cycle. At most one issue per cycle.
- Fill: Dmem_tag != 0 matching a WAIT entry's mem_tag -> wr0_en = 1 with that entry's idx/tag; entry completes, -> FREE. Every MERGED entry with same idx/tag latches Dmem_data, -> PEND. Dmem_tag matching nothing is ignored.
- Completion source per cycle, priority: fill primary > lowest-index PEND entry (-> FREE) > accepted hit. One completion per cycle, registered into done_* at next edge.
- ld_ready = no fill this cycle AND no PEND entry AND (rd1_valid OR (free MSHR AND block-conflict rule satisfied)).
- Accepted hit: completes with rd1_data. Accepted miss: allocates lowest-index FREE entry.
- Block conflict: miss to idx/tag already held by ISSUE/WAIT entry handled per Configuration. A miss to the same idx but different tag as a pending entry is allowed; last fill wins the line.
- mshr_empty = all entries FREE.

## Timing
- Reset (reset low, async): all MSHRs FREE; done_valid = 0, done_id = 0, done_data = 0; Dmem_command = 0; wr0_en = 0; mshr_empty = 1; ld_ready follows combinational rule.
- Hit latency: done_valid one cycle after acceptance.
- Miss latency: done_valid one cycle after the fill cycle for the primary; merged secondaries one per subsequent cycle in index order.
- Fill and issue in same cycle allowed; fill-freed entry reusable next cycle, not same cycle.
- Dmem_response sampled only in cycles where Dmem_command = BUS_LOAD.
- Reset mid-miss discards all entries; a later Dmem_tag for a discarded transaction is ignored.

## Configuration
- DCACHE_MSHR_MERGE_EN defined: a miss matching a pending primary's idx/tag allocates a MERGED entry (if free) and issues no bus request.
- Undefined: such a miss is not accepted (ld_ready = 0) until the primary frees; MERGED/PEND states never entered.

## Test plan
- Hit: rd1_valid = 1, rd1_data = 64'hDEAD, ld_id = 3 -> next cycle done_valid = 1, done_id = 3, done_data = 64'hDEAD; no Dmem_command.
- Miss with retry: ld_addr = 64'h1238, Dmem_response = 0 then 5 -> BUS_LOAD, Dmem_addr = 64'h1238 two cycles; Dmem_tag = 5, Dmem_data = 64'hBEEF -> wr0_en, wr0_idx = 7'h47, wr0_tag = 22'h4; next cycle done_data = 64'hBEEF.
- Merge (macro on): two misses to 64'h1238 ids 1, 2 -> one BUS_LOAD; after fill done id 1 then id 2 on consecutive cycles, both 64'hBEEF. Macro off: second load held (ld_ready = 0) until fill, then hits.
- Full: NUM_MSHR misses to distinct blocks, no fills -> ld_ready = 0 on next miss, mshr_empty = 0; hit still accepted.
- Out-of-order fills: tags 1, 2 issued, Dmem_tag 2 then 1 -> completions in fill order with correct ids; mshr_empty = 1 after.
- Async reset while two entries WAIT -> outputs clear immediately; subsequent Dmem_tag = 1 produces no wr0_en/done_valid.
